ysyx_22041211_lsu: RTL and testbench

YSYX_22041211_LSU -- requirements
Module: ysyx_22041211_LSU

---
 rtl/ysyx_22041211_lsu.sv | 194 +++++++++++++++++++
 tb/tb_ysyx_22041211_lsu.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: one outstanding RV32I memory access over a req/gnt + rvalid bus.
// Legality and alignment are decided on acceptance. Bad requests never reach memory.
module ysyx_22041211_lsu #(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // core side
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [DATA_LEN-1:0] alu_result,
  input  logic [DATA_LEN-1:0] store_data,
  input  logic                is_store,
  input  logic [2:0]          funct3,
  output logic                lsu_done,
  output logic                lsu_err,
  output logic [DATA_LEN-1:0] lsu_rdata,
  // memory side
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic [3:0]          mem_wmask,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Request latched on acceptance
  logic [DATA_LEN-1:0] r_addr;
  logic [DATA_LEN-1:0] r_wdata;
  logic [3:0]          r_wmask;
  logic                r_store;
  logic [2:0]          r_funct3;
  logic                r_err;
  logic [DATA_LEN-1:0] r_rdata;

  // Decode of the incoming request
  logic                w_accept;
  logic                w_in_legal;
  logic                w_in_misalign;
  logic                w_in_err;
  logic [4:0]          w_in_shamt;
  logic [3:0]          w_in_wmask;
  logic [DATA_LEN-1:0] w_in_wdata;

  // Load return path
  logic [4:0]          w_rd_shamt;
  logic [DATA_LEN-1:0] w_rd_shift;
  logic [DATA_LEN-1:0] w_load_ext;

  assign w_accept   = (r_state == StIdle) && lsu_valid;
  assign w_in_shamt = {alu_result[1:0], 3'b000};
  assign w_in_err   = !w_in_legal || w_in_misalign;
  assign w_in_wdata = store_data << w_in_shamt;

  // Legal funct3 codes differ between loads and stores
  always_comb begin
    w_in_legal = 1'b0;
    if (is_store) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: w_in_legal = 1'b1;
        default:                w_in_legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_in_legal = 1'b1;
        default:                                w_in_legal = 1'b0;
      endcase
    end
  end

  // Alignment check keyed on access size funct3[1:0]
  always_comb begin
    w_in_misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   w_in_misalign = alu_result[0];
      2'b10:   w_in_misalign = (alu_result[1:0] != 2'b00);
      default: w_in_misalign = 1'b0;
    endcase
  end

  // Byte-lane mask for the store, placed at the addressed lane
  always_comb begin
    w_in_wmask = 4'b0000;
    case (funct3[1:0])
      2'b00:   w_in_wmask = 4'b0001 << alu_result[1:0];
      2'b01:   w_in_wmask = 4'b0011 << alu_result[1:0];
      default: w_in_wmask = 4'b1111;
    endcase
  end

  assign w_rd_shamt = {r_addr[1:0], 3'b000};
  assign w_rd_shift = mem_rdata >> w_rd_shamt;

  // Sign- or zero-extend the lane-aligned load word
  always_comb begin
    w_load_ext = w_rd_shift;
    case (r_funct3)
      3'b000:  w_load_ext = {{(DATA_LEN-8){w_rd_shift[7]}}, w_rd_shift[7:0]};
      3'b001:  w_load_ext = {{(DATA_LEN-16){w_rd_shift[15]}}, w_rd_shift[15:0]};
      3'b100:  w_load_ext = {{(DATA_LEN-8){1'b0}}, w_rd_shift[7:0]};
      3'b101:  w_load_ext = {{(DATA_LEN-16){1'b0}}, w_rd_shift[15:0]};
      default: w_load_ext = w_rd_shift;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; gnt/rvalid only matter in their own state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (lsu_valid) begin
          w_state_next = w_in_err ? StResp : StReq;
        end
      end
      StReq: begin
        if (mem_gnt) begin
          w_state_next = r_store ? StResp : StWait;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Request capture on acceptance; load data capture in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wmask  <= 4'b0000;
      r_store  <= 1'b0;
      r_funct3 <= 3'b000;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= alu_result;
        r_wdata  <= w_in_wdata;
        r_wmask  <= w_in_wmask;
        r_store  <= is_store;
        r_funct3 <= funct3;
        r_err    <= w_in_err;
        // Stores and errors report zero data
        r_rdata  <= '0;
      end else if ((r_state == StWait) && mem_rvalid) begin
        r_rdata <= w_load_ext;
      end
    end
  end

  // Outputs decoded from state so reset clears them immediately
  always_comb begin
    lsu_ready = (r_state == StIdle);
    mem_req   = (r_state == StReq);
    mem_we    = (r_state == StReq) && r_store;
    mem_wmask = ((r_state == StReq) && r_store) ? r_wmask : 4'b0000;
    mem_addr  = {r_addr[DATA_LEN-1:2], 2'b00};
    mem_wdata = r_wdata;
    lsu_done  = (r_state == StResp);
    lsu_err   = (r_state == StResp) && r_err;
    lsu_rdata = (r_state == StResp) ? r_rdata : '0;
  end

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Bench for the LSU: a timeline model predicts, per cycle, ready/req/done and their payloads
// from each directed request and the scripted memory latency; a compare process checks them.
module tb_ysyx_22041211_lsu;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        is_store;
  logic [2:0]  funct3;
  logic        lsu_done;
  logic        lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  ysyx_22041211_lsu #(.DATA_LEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .alu_result (alu_result),
    .store_data (store_data),
    .is_store   (is_store),
    .funct3     (funct3),
    .lsu_done   (lsu_done),
    .lsu_err    (lsu_err),
    .lsu_rdata  (lsu_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Expected timeline, keyed by cycle number
  bit          busy_at[int];
  req_t        req_at[int];
  rsp_t        done_at[int];
  bit          gnt_at[int];
  logic [31:0] rv_at[int];
  bit          junk_gnt[int];
  bit          junk_rv[int];

  // Observations captured by the compare process
  int          done_q[$];
  int          req_seen = 0;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wmask;
  logic        last_err;
  logic [31:0] last_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // What a request must produce, from the ISA rules alone
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd, output logic err,
                                output logic [31:0] rdata, output logic [31:0] wdata,
                                output logic [3:0] wmask);
    int     off;
    int     nb;
    bit     legal;
    longint v;
    off   = int'(a % 32'd4);
    nb    = 1 << f3[1:0];
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || ((a % 32'(nb)) != 32'd0);
    wdata = sd << (8 * off);
    wmask = 4'b0000;
    rdata = 32'd0;
    if (!err && st) wmask = 4'(((1 << nb) - 1) << off);
    if (!err && !st) begin
      v = longint'(rd >> (8 * off));
      if (nb < 4) begin
        v = v % (longint'(1) << (8 * nb));
        if (!f3[2] && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      end
      rdata = 32'(v);
    end
  endfunction

  // Memory responder: scripted gnt/rvalid plus stray pulses the LSU must ignore
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt = gnt_at.exists(cyc) || junk_gnt.exists(cyc);
      if (rv_at.exists(cyc)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rv_at[cyc];
      end else begin
        mem_rvalid = junk_rv.exists(cyc);
        mem_rdata  = $urandom;
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the timeline
  always @(negedge clk) begin
    check("lsu_ready", 32'(lsu_ready), 32'(!busy_at.exists(cyc)));
    check("mem_req", 32'(mem_req), 32'(req_at.exists(cyc)));
    if (mem_req) begin
      req_seen++;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
      last_wmask = mem_wmask;
    end
    if (req_at.exists(cyc)) begin
      check("mem_addr", mem_addr, req_at[cyc].addr);
      check("mem_we", 32'(mem_we), 32'(req_at[cyc].we));
      check("mem_wmask", 32'(mem_wmask), 32'(req_at[cyc].wmask));
      if (req_at[cyc].we) check("mem_wdata", mem_wdata, req_at[cyc].wdata);
    end
    check("lsu_done", 32'(lsu_done), 32'(done_at.exists(cyc)));
    if (lsu_done) begin
      done_q.push_back(cyc);
      last_err   = lsu_err;
      last_rdata = lsu_rdata;
    end
    if (done_at.exists(cyc)) begin
      check("lsu_err", 32'(lsu_err), 32'(done_at[cyc].err));
      check("lsu_rdata", lsu_rdata, done_at[cyc].rdata);
    end
  end

  task automatic abandon(input int from);
    for (int c = from; c < from + 64; c++) begin
      busy_at.delete(c);
      req_at.delete(c);
      done_at.delete(c);
    end
  endtask

  // Issue one request in the current slot (posedge+1). g = stall cycles before gnt,
  // r = cycles from gnt to rvalid, rst_after = cycle offset to pulse reset (0 = none).
  // Returns in the first idle slot after the response.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input int g, input int r,
                       input int rst_after, output int t0);
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          tg;
    int          tr;
    int          tdone;
    bit          aborted;
    req_t        rq;
    rsp_t        rs;
    model(st, f3, a, sd, rd, err, rdata, wdata, wmask);
    t0         = cyc;
    lsu_valid  = 1'b1;
    is_store   = st;
    funct3     = f3;
    alu_result = a;
    store_data = sd;
    aborted    = 1'b0;
    if (err) begin
      // Error requests skip memory entirely
      tdone = t0 + 1;
      junk_gnt[t0 + 1] = 1'b1;
    end else begin
      tg = t0 + 1 + g;
      rq = '{we: st, addr: a & 32'hFFFF_FFFC, wdata: wdata, wmask: wmask};
      for (int c = t0 + 1; c <= tg; c++) req_at[c] = rq;
      gnt_at[tg] = 1'b1;
      if (g >= 1) junk_rv[t0 + 1] = 1'b1;
      if (st) begin
        tdone = tg + 1;
        junk_gnt[tdone] = 1'b1;
      end else begin
        tr = tg + r;
        rv_at[tr]   = rd;
        junk_rv[tg] = 1'b1;
        if (r >= 2) junk_gnt[tg + 1] = 1'b1;
        tdone = tr + 1;
      end
    end
    for (int c = t0 + 1; c <= tdone; c++) busy_at[c] = 1'b1;
    rs = '{err: err, rdata: rdata};
    done_at[tdone] = rs;
    for (int k = 1; k <= tdone - t0 + 1; k++) begin
      @(posedge clk);
      #1;
      if (!rst_n) rst_n = 1'b1;
      if (k == rst_after) begin
        lsu_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        abandon(cyc);
        aborted = 1'b1;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ready", 32'(lsu_ready), 32'd1);
        check("rst_done", 32'(lsu_done), 32'd0);
        check("rst_wmask", 32'(mem_wmask), 32'd0);
      end else if (k == tdone - t0 + 1 || aborted) begin
        lsu_valid = 1'b0;
      end else begin
        // Busy-cycle noise on the request port
        lsu_valid  = 1'($urandom_range(0, 1));
        is_store   = 1'($urandom_range(0, 1));
        funct3     = 3'($urandom_range(0, 7));
        alu_result = $urandom;
        store_data = $urandom;
      end
    end
  endtask

  int t0;
  int nreq;
  int n0;

  initial begin
    rst_n      = 1'b0;
    lsu_valid  = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'b000;
    alu_result = 32'd0;
    store_data = 32'd0;
    #2;
    check("reset_ready", 32'(lsu_ready), 32'd1);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_wmask", 32'(mem_wmask), 32'd0);
    check("reset_done", 32'(lsu_done), 32'd0);
    check("reset_err", 32'(lsu_err), 32'd0);
    check("reset_rdata", lsu_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LB, presented in the same slot reset is released
    issue(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 1, 0, t0);
    check("lb_addr", last_addr, 32'h0000_1000);
    check("lb_rdata", last_rdata, 32'hFFFF_FF80);
    check("lb_err", 32'(last_err), 32'd0);
    check("lb_latency", 32'(done_q[done_q.size() - 1] - t0), 32'd3);

    issue(1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 1, 2, 0, t0);
    check("lhu_rdata", last_rdata, 32'h0000_BEEF);

    // SB with three stall cycles before gnt
    issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'd0, 3, 1, 0, t0);
    check("sb_wmask", 32'(last_wmask), 32'h0000_0002);
    check("sb_wdata", last_wdata, 32'h0000_AB00);
    check("sb_latency", 32'(done_q[done_q.size() - 1] - t0), 32'd5);

    nreq = req_seen;
    issue(1'b0, 3'b010, 32'h0000_4002, 32'd0, 32'd0, 0, 1, 0, t0);
    check("lw_mis_err", 32'(last_err), 32'd1);
    check("lw_mis_rdata", last_rdata, 32'd0);
    check("lw_mis_noreq", 32'(req_seen - nreq), 32'd0);
    check("lw_mis_latency", 32'(done_q[done_q.size() - 1] - t0), 32'd1);

    nreq = req_seen;
    issue(1'b0, 3'b011, 32'h0000_4000, 32'd0, 32'd0, 0, 1, 0, t0);
    check("f3_011_err", 32'(last_err), 32'd1);
    check("f3_011_noreq", 32'(req_seen - nreq), 32'd0);

    issue(1'b1, 3'b100, 32'h0000_5000, 32'h1234_5678, 32'd0, 0, 1, 0, t0);
    check("st_f3_100_err", 32'(last_err), 32'd1);
    issue(1'b1, 3'b001, 32'h0000_5001, 32'h1234_5678, 32'd0, 0, 1, 0, t0);
    check("sh_mis_err", 32'(last_err), 32'd1);

    issue(1'b0, 3'b001, 32'h0000_6002, 32'd0, 32'h8001_7777, 0, 1, 0, t0);
    check("lh_rdata", last_rdata, 32'hFFFF_8001);
    issue(1'b0, 3'b100, 32'h0000_7001, 32'd0, 32'h1234_F05A, 2, 1, 0, t0);
    check("lbu_rdata", last_rdata, 32'h0000_00F0);
    issue(1'b0, 3'b010, 32'h0000_7000, 32'd0, 32'hDEAD_BEEF, 2, 3, 0, t0);
    check("lw_rdata", last_rdata, 32'hDEAD_BEEF);
    issue(1'b1, 3'b001, 32'h0000_8002, 32'h0000_CAFE, 32'd0, 1, 1, 0, t0);
    check("sh_wmask", 32'(last_wmask), 32'h0000_000C);
    check("sh_wdata", last_wdata, 32'hCAFE_0000);

    // Back-to-back SW with immediate gnt
    issue(1'b1, 3'b010, 32'h0000_9000, 32'h1122_3344, 32'd0, 0, 1, 0, t0);
    issue(1'b1, 3'b010, 32'h0000_9004, 32'h5566_7788, 32'd0, 0, 1, 0, t0);
    check("sw_b2b_gap",
          32'(done_q[done_q.size() - 1] - done_q[done_q.size() - 2]), 32'd3);
    check("sw_wmask", 32'(last_wmask), 32'h0000_000F);

    // LW abandoned by reset in WAIT; its later rvalid must be ignored
    n0 = done_q.size();
    issue(1'b0, 3'b010, 32'h0000_A000, 32'd0, 32'h5555_AAAA, 0, 4, 2, t0);
    check("rst_abandon_no_done", 32'(done_q.size() - n0), 32'd0);

    issue(1'b1, 3'b010, 32'h0000_B000, 32'hA5A5_5A5A, 32'd0, 0, 1, 0, t0);
    check("post_rst_sw_err", 32'(last_err), 32'd0);
    check("post_rst_sw_wdata", last_wdata, 32'hA5A5_5A5A);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
